// File: rtl/ram8_clr.sv
// ram8_clr: eight-entry register file with a one-hot write demux, a combinational read mux,
// a sequenced bulk-clear sweep and per-entry written flags.
module ram8_clr #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic [7:0]       written
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [7:0]       written_q, written_d;

  logic       host_wr;
  logic [2:0] wr_idx;
  logic [7:0] wr_en;
  logic [WIDTH-1:0] wr_data;

  // Control: pick the write source (host or sweep) and the next FSM state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    host_wr = 1'b0;
    wr_idx  = address;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          // Clear wins over a simultaneous load; nothing is written at this edge.
          state_d = StSweep;
          cnt_d   = 3'd0;
        end else if (load) begin
          host_wr = 1'b1;
        end
      end
      StSweep: begin
        wr_idx = cnt_q;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // One-hot demux of the write strobe onto the eight entries.
  always_comb begin
    wr_en = 8'h00;
    if (host_wr || (state_q == StSweep)) begin
      unique case (wr_idx)
        3'd0: wr_en = 8'b0000_0001;
        3'd1: wr_en = 8'b0000_0010;
        3'd2: wr_en = 8'b0000_0100;
        3'd3: wr_en = 8'b0000_1000;
        3'd4: wr_en = 8'b0001_0000;
        3'd5: wr_en = 8'b0010_0000;
        3'd6: wr_en = 8'b0100_0000;
        3'd7: wr_en = 8'b1000_0000;
        default: wr_en = 8'h00;
      endcase
    end
  end

  // Next-state of the storage array and written flags from the demuxed strobe.
  always_comb begin
    wr_data   = host_wr ? in : '0;
    written_d = written_q;
    for (int k = 0; k < 8; k++) begin
      mem_d[k] = mem_q[k];
      if (wr_en[k]) begin
        mem_d[k]     = wr_data;
        written_d[k] = host_wr;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      written_q <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      written_q <= written_d;
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  // Combinational read mux and status outputs.
  always_comb begin
    out     = mem_q[address];
    busy    = (state_q == StSweep);
    written = written_q;
  end

endmodule

// File: tb/tb_ram8_clr.sv
// tb_ram8_clr: directed self-checking bench for ram8_clr.
module tb_ram8_clr;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic [7:0]  written;

  int n_checks = 0;
  int n_fail   = 0;

  ram8_clr #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy),
    .written (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      n_checks++;
      if (out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got %h expected 0000", k, out);
      end
    end
    n_checks++;
    if (written !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_written: got %h expected 00", written);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_write_all();
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      in      = 16'h1000 + 16'(k);
      load    = 1'b1;
      #1;
      n_checks++;
      if (out !== 16'h0000) begin
        n_fail++;
        $display("FAIL rdw_old[%0d]: got %h expected 0000", k, out);
      end
      step();
      n_checks++;
      if (out !== 16'h1000 + 16'(k)) begin
        n_fail++;
        $display("FAIL write_lat[%0d]: got %h expected %h", k, out, 16'h1000 + 16'(k));
      end
      n_checks++;
      if (written !== 8'((16'h1 << (k + 1)) - 1)) begin
        n_fail++;
        $display("FAIL write_flag[%0d]: got %h expected %h", k, written,
                 8'((16'h1 << (k + 1)) - 1));
      end
    end
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      n_checks++;
      if (out !== 16'h1000 + 16'(k)) begin
        n_fail++;
        $display("FAIL readback[%0d]: got %h expected %h", k, out, 16'h1000 + 16'(k));
      end
    end
  endtask

  task automatic test_clear_sweep();
    address = 3'd3;
    in      = 16'hBEEF;
    load    = 1'b1;
    step();
    load  = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_busy[%0d]: got %b expected 1", i, busy);
      end
      step();
      if (i == 4) begin
        address = 3'd3;
        #1;
        n_checks++;
        if (out !== 16'h0000) begin
          n_fail++;
          $display("FAIL mid_sweep_a3: got %h expected 0000", out);
        end
        address = 3'd5;
        #1;
        n_checks++;
        if (out !== 16'h1005) begin
          n_fail++;
          $display("FAIL mid_sweep_a5: got %h expected 1005", out);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end_busy: got %b expected 0", busy);
    end
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      n_checks++;
      if (out !== 16'h0000) begin
        n_fail++;
        $display("FAIL cleared[%0d]: got %h expected 0000", k, out);
      end
    end
    n_checks++;
    if (written !== 8'h00) begin
      n_fail++;
      $display("FAIL cleared_written: got %h expected 00", written);
    end
  endtask

  task automatic test_sweep_ignore();
    address = 3'd6;
    in      = 16'h6666;
    load    = 1'b1;
    step();
    load  = 1'b0;
    clear = 1'b1;
    step();
    clear   = 1'b0;
    load    = 1'b1;
    address = 3'd6;
    in      = 16'hFFFF;
    for (int i = 1; i <= 8; i++) begin
      clear = (i == 3);
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ign_busy[%0d]: got %b expected 1", i, busy);
      end
      step();
    end
    load  = 1'b0;
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_end_busy: got %b expected 0", busy);
    end
    address = 3'd6;
    #1;
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL ign_a6: got %h expected 0000", out);
    end
    n_checks++;
    if (written !== 8'h00) begin
      n_fail++;
      $display("FAIL ign_written: got %h expected 00", written);
    end
  endtask

  task automatic test_clear_load_priority();
    address = 3'd2;
    in      = 16'h1234;
    load    = 1'b1;
    clear   = 1'b1;
    step();
    load  = 1'b0;
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_busy: got %b expected 1", busy);
    end
    n_checks++;
    if (written !== 8'h00) begin
      n_fail++;
      $display("FAIL prio_written: got %h expected 00", written);
    end
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL prio_a2: got %h expected 0000", out);
    end
    for (int i = 0; i < 20 && busy === 1'b1; i++) step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_timeout: busy %b expected 0 within 20 cycles", busy);
    end
  endtask

  task automatic test_clear_held();
    clear = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_gap: got %b expected 0", busy);
    end
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_restart: got %b expected 1", busy);
    end
    clear = 1'b0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_timeout: busy %b expected 0 within 20 cycles", busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    address = 3'd5;
    in      = 16'h5A5A;
    load    = 1'b1;
    step();
    load  = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (written !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_written: got %h expected 00", written);
    end
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid_a5: got %h expected 0000", out);
    end
    @(negedge clk);
    reset   = 1'b0;
    address = 3'd7;
    in      = 16'h00AA;
    load    = 1'b1;
    step();
    load = 1'b0;
    n_checks++;
    if (out !== 16'h00AA) begin
      n_fail++;
      $display("FAIL post_rst_a7: got %h expected 00aa", out);
    end
    n_checks++;
    if (written !== 8'h80) begin
      n_fail++;
      $display("FAIL post_rst_written: got %h expected 80", written);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    reset   = 1'b1;
    in      = 16'h0000;
    load    = 1'b0;
    address = 3'd0;
    clear   = 1'b0;
    #2;
    test_reset();
    #2;
    reset = 1'b0;
    step();
    test_write_all();
    test_clear_sweep();
    test_sweep_ignore();
    test_clear_load_priority();
    test_clear_held();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
